// File: rtl/immenc_pkg.sv
// Shared constants for the immenc instruction encoder: format codes, opcodes,
// immediate range limits and FSM state encodings.
package immenc_pkg;

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_LI   = 3'd6;
  localparam logic [2:0] FMT_RSVD = 3'd7;

  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

  localparam logic signed [31:0] IMM_I_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM_I_MAX =  32'sd2047;
  localparam logic signed [31:0] IMM_B_MIN = -32'sd4096;
  localparam logic signed [31:0] IMM_B_MAX =  32'sd4094;
  localparam logic signed [31:0] IMM_J_MIN = -32'sd1048576;
  localparam logic signed [31:0] IMM_J_MAX =  32'sd1048574;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FULL    = 2'd1;
  localparam logic [1:0] ST_HOLD_HI = 2'd2;

endpackage

// File: rtl/immenc_pack.sv
// Combinational RVI packer: format + fields + immediate -> instruction word
// plus an out-of-range / illegal-format flag. Formats 6 and 7 pack as NOP.
module immenc_pack
  import immenc_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_err
);

  logic signed [31:0] w_imm_s;
  assign w_imm_s = $signed(i_imm);

  always_comb begin
    o_word = NOP_WORD;
    o_err  = 1'b0;
    case (i_fmt)
      FMT_R: o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      FMT_I: begin
        o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        o_err  = (w_imm_s < IMM_I_MIN) || (w_imm_s > IMM_I_MAX);
      end
      FMT_S: begin
        o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        o_err  = (w_imm_s < IMM_I_MIN) || (w_imm_s > IMM_I_MAX);
      end
      FMT_B: begin
        o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                  i_imm[4:1], i_imm[11], i_opcode};
        o_err  = (w_imm_s < IMM_B_MIN) || (w_imm_s > IMM_B_MAX) || i_imm[0];
      end
      FMT_U: begin
        o_word = {i_imm[31:12], i_rd, i_opcode};
        o_err  = (i_imm[11:0] != 12'd0);
      end
      FMT_J: begin
        o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        o_err  = (w_imm_s < IMM_J_MIN) || (w_imm_s > IMM_J_MAX) || i_imm[0];
      end
      FMT_LI, FMT_RSVD: begin
        // LI is rewritten into I/U by the top before reaching here
        o_word = NOP_WORD;
        o_err  = 1'b1;
      end
      default: begin
        o_word = NOP_WORD;
        o_err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/immenc.sv
// Registered RISC-V instruction encoder with valid/ready on both sides.
// Define IMMENC_LI_EN to build the LI -> LUI+ADDI pseudo-op expansion.
module immenc
  import immenc_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_fmt,
  input  logic [6:0]      in_opcode,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [BITS-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_instr,
  output logic            out_range_err,
  output logic            out_last
);

  generate
    if (BITS != 32) begin : g_bits_check
      $error("immenc supports only BITS == 32");
    end
  endgenerate

  logic [1:0]  r_state;
  logic [31:0] r_instr;
  logic        r_err;
  logic        w_accept;
  logic        w_split;

  logic [2:0]  w_p_fmt;
  logic [6:0]  w_p_opcode;
  logic [4:0]  w_p_rd;
  logic [4:0]  w_p_rs1;
  logic [2:0]  w_p_funct3;
  logic [31:0] w_p_imm;
  logic [31:0] w_word;
  logic        w_err;

  assign in_ready  = rst_n && ((r_state == ST_EMPTY) ||
                               ((r_state == ST_FULL) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state != ST_EMPTY);
  assign out_instr = r_instr;
  assign out_range_err = r_err;

`ifdef IMMENC_LI_EN
  logic [4:0]  r_li_rd;
  logic [11:0] r_li_lo;
  logic        r_last;
  logic [31:0] w_li_sum;
  logic        w_li_fits;

  // Rounding add: ADDI sign-extends lo, so hi absorbs the borrow
  assign w_li_sum  = in_imm + 32'h0000_0800;
  assign w_li_fits = ($signed(in_imm) >= IMM_I_MIN) && ($signed(in_imm) <= IMM_I_MAX);
  assign w_split   = (in_fmt == FMT_LI) && !w_li_fits && (in_imm[11:0] != 12'd0);
  assign out_last  = r_last;
`else
  assign w_split   = 1'b0;
  assign out_last  = 1'b1;
`endif

  always_comb begin
    w_p_fmt    = in_fmt;
    w_p_opcode = in_opcode;
    w_p_rd     = in_rd;
    w_p_rs1    = in_rs1;
    w_p_funct3 = in_funct3;
    w_p_imm    = in_imm;
`ifdef IMMENC_LI_EN
    if (r_state == ST_HOLD_HI) begin
      w_p_fmt    = FMT_I;
      w_p_opcode = OPC_OP_IMM;
      w_p_rd     = r_li_rd;
      w_p_rs1    = r_li_rd;
      w_p_funct3 = 3'd0;
      w_p_imm    = {{20{r_li_lo[11]}}, r_li_lo};
    end else if (in_fmt == FMT_LI) begin
      if (w_li_fits) begin
        w_p_fmt    = FMT_I;
        w_p_opcode = OPC_OP_IMM;
        w_p_rs1    = 5'd0;
        w_p_funct3 = 3'd0;
      end else begin
        w_p_fmt    = FMT_U;
        w_p_opcode = OPC_LUI;
        w_p_imm    = {w_li_sum[31:12], 12'd0};
      end
    end
`endif
  end

  immenc_pack u_pack (
    .i_fmt    (w_p_fmt),
    .i_opcode (w_p_opcode),
    .i_rd     (w_p_rd),
    .i_rs1    (w_p_rs1),
    .i_rs2    (in_rs2),
    .i_funct3 (w_p_funct3),
    .i_funct7 (in_funct7),
    .i_imm    (w_p_imm),
    .o_word   (w_word),
    .o_err    (w_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_instr <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_instr <= w_word;
      r_err   <= w_err;
      r_state <= w_split ? ST_HOLD_HI : ST_FULL;
    end else if ((r_state == ST_HOLD_HI) && out_ready) begin
      r_instr <= w_word;
      r_err   <= w_err;
      r_state <= ST_FULL;
    end else if ((r_state == ST_FULL) && out_ready) begin
      r_state <= ST_EMPTY;
    end
  end

`ifdef IMMENC_LI_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= 1'b0;
      r_li_rd <= 5'd0;
      r_li_lo <= 12'd0;
    end else if (w_accept) begin
      r_last  <= !w_split;
      r_li_rd <= in_rd;
      r_li_lo <= in_imm[11:0];
    end else if ((r_state == ST_HOLD_HI) && out_ready) begin
      r_last  <= 1'b1;
    end
  end
`endif

endmodule
